// File: rtl/cu_edge_data_write_accumulate.sv
// Coalesces per-element 32-bit edge data writes into cacheline-wide records with a slot mask.
// Optional build macro CU_WRITE_ACCUM_ENDIAN_SWAP_EN byte-reverses each element on insertion.
module cu_edge_data_write_accumulate #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned CACHELINE_BYTES = 128,
    parameter int unsigned SLOTS           = CACHELINE_BYTES * 8 / DATA_WIDTH,
    parameter int unsigned INDEX_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter int unsigned SLOT_W          = $clog2(SLOTS)
) (
    input  logic                          clock,
    input  logic                          rstn,
    input  logic                          enabled_in,
    input  logic                          in_valid,
    input  logic [INDEX_WIDTH-1:0]        in_index,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [7:0]                    in_cu_id,
    output logic                          in_ready,
    input  logic                          flush_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INDEX_WIDTH-SLOT_W-1:0] out_line_index,
    output logic [CACHELINE_BYTES*8-1:0]  out_data,
    output logic [SLOTS-1:0]              out_slot_mask,
    output logic [7:0]                    out_cu_id,
    output logic [SLOT_W:0]               out_count,
    output logic                          busy_out
);

    localparam int unsigned LINE_W = INDEX_WIDTH - SLOT_W;
    localparam int unsigned CNT_W  = SLOT_W + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic                                r_enabled;
    logic                                r_out_valid;
    logic [LINE_W-1:0]                   r_line;
    logic [7:0]                          r_cu_id;
    logic [SLOTS-1:0]                    r_mask;
    logic [CNT_W-1:0]                    r_count;
    logic [TMR_W-1:0]                    r_timer;
    logic [SLOTS-1:0][DATA_WIDTH-1:0]    r_data;

    logic [SLOT_W-1:0]                   w_slot;
    logic [LINE_W-1:0]                   w_line;
    logic                                w_line_hit;
    logic                                w_accept;
    logic [SLOTS-1:0]                    w_slot_onehot;
    logic [SLOTS-1:0]                    w_mask_acc;
    logic                                w_mask_full;
    logic                                w_new_slot;
    logic                                w_timeout;
    logic                                w_miss;
    logic [DATA_WIDTH-1:0]               w_wdata;

    assign w_slot      = in_index[SLOT_W-1:0];
    assign w_line      = in_index[INDEX_WIDTH-1:SLOT_W];
    assign w_line_hit  = (w_line == r_line);
    assign in_ready    = r_enabled && (r_state != ST_EMIT) && !((r_state == ST_ACCUM) && !w_line_hit);
    assign w_accept    = in_valid && in_ready;
    assign w_mask_acc  = r_mask | w_slot_onehot;
    assign w_mask_full = &w_mask_acc;
    assign w_new_slot  = ~|(r_mask & w_slot_onehot);
    // Timeout and line-miss are only honoured while enabled so a disabled block keeps its open line.
    assign w_timeout   = r_enabled && (r_timer == TMR_LAST);
    assign w_miss      = r_enabled && in_valid && !w_line_hit;

    always_comb begin
        w_slot_onehot         = '0;
        w_slot_onehot[w_slot] = 1'b1;
    end

    always_comb begin
        w_wdata = '0;
`ifdef CU_WRITE_ACCUM_ENDIAN_SWAP_EN
        for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
            w_wdata[b*8 +: 8] = in_data[DATA_WIDTH - 8 - b*8 +: 8];
        end
`else
        w_wdata = in_data;
`endif
    end

    always_ff @(posedge clock or posedge rstn) begin
        if (rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    if (w_mask_full || flush_in) begin
                        w_state_nxt = ST_EMIT;
                    end
                end else if (w_miss || flush_in || w_timeout) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Line accumulation; the accumulation registers double as the held output record during EMIT.
    always_ff @(posedge clock or posedge rstn) begin
        if (rstn) begin
            r_enabled   <= 1'b0;
            r_out_valid <= 1'b0;
            r_line      <= '0;
            r_cu_id     <= '0;
            r_mask      <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_data      <= '0;
        end else begin
            r_enabled   <= enabled_in;
            r_out_valid <= (w_state_nxt == ST_EMIT);
            if (r_state == ST_EMIT) begin
                if (out_ready) begin
                    r_mask  <= '0;
                    r_count <= '0;
                    r_timer <= '0;
                    r_data  <= '0;
                end
            end else if (w_accept) begin
                r_data[w_slot] <= w_wdata;
                r_timer        <= '0;
                if (r_state == ST_IDLE) begin
                    r_line  <= w_line;
                    r_cu_id <= in_cu_id;
                    r_mask  <= w_slot_onehot;
                    r_count <= CNT_W'(1);
                end else begin
                    r_mask <= w_mask_acc;
                    if (w_new_slot) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
            end else if ((r_state == ST_ACCUM) && r_enabled && (r_timer != TMR_LAST)) begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_line_index = r_line;
    assign out_data       = r_data;
    assign out_slot_mask  = r_mask;
    assign out_cu_id      = r_cu_id;
    assign out_count      = r_count;
    assign busy_out       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cu_edge_data_write_accumulate.sv
// Self-checking bench for cu_edge_data_write_accumulate: vector table, scoreboard of expected line records.
module tb_cu_edge_data_write_accumulate;

    logic          clock = 1'b0;
    logic          rstn;
    logic          enabled_in;
    logic          in_valid;
    logic [31:0]   in_index;
    logic [31:0]   in_data;
    logic [7:0]    in_cu_id;
    logic          in_ready;
    logic          flush_in;
    logic          out_valid;
    logic          out_ready;
    logic [26:0]   out_line_index;
    logic [1023:0] out_data;
    logic [31:0]   out_slot_mask;
    logic [7:0]    out_cu_id;
    logic [5:0]    out_count;
    logic          busy_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [26:0]   line;
        logic [31:0]   mask;
        logic [5:0]    cnt;
        logic [7:0]    cu;
        logic [1023:0] data;
    } rec_t;

    typedef struct {
        logic        v;
        logic [31:0] idx;
        logic [31:0] dat;
        logic        fl;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic        e_busy;
    } vec_t;

    rec_t sb[$];

    cu_edge_data_write_accumulate dut (
        .clock          (clock),
        .rstn           (rstn),
        .enabled_in     (enabled_in),
        .in_valid       (in_valid),
        .in_index       (in_index),
        .in_data        (in_data),
        .in_cu_id       (in_cu_id),
        .in_ready       (in_ready),
        .flush_in       (flush_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_line_index (out_line_index),
        .out_data       (out_data),
        .out_slot_mask  (out_slot_mask),
        .out_cu_id      (out_cu_id),
        .out_count      (out_count),
        .busy_out       (busy_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] exp_word(input logic [31:0] d);
`ifdef CU_WRITE_ACCUM_ENDIAN_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    function automatic rec_t mk(input logic [26:0] line, input logic [7:0] cu);
        rec_t r;
        r.line = line; r.mask = '0; r.cnt = '0; r.cu = cu; r.data = '0;
        return r;
    endfunction

    function automatic rec_t add(input rec_t r_in, input int slot, input logic [31:0] d);
        rec_t r = r_in;
        if (!r.mask[slot]) r.cnt = r.cnt + 6'd1;
        r.mask[slot] = 1'b1;
        r.data[slot*32 +: 32] = exp_word(d);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < 32; k++) begin
                if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
                    $display("FAIL %s slot %0d: got %h expected %h", name, k, act[k*32 +: 32], exp[k*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    // One input cycle: drive at edge+1, sample in_ready at edge+2, return at next edge+1.
    task automatic step(input logic v, input logic [31:0] idx, input logic [31:0] d,
                        input logic fl, input logic ordy, output logic rdy);
        in_valid = v; in_index = idx; in_data = d; flush_in = fl; out_ready = ordy;
        #1 rdy = in_ready;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush_in = 1'b0;
    endtask

    // Scoreboard: compare each record at the cycle its handshake is taken.
    always @(negedge clock) begin
        if (!rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_record", 64'(out_line_index), 64'h7fff_ffff);
            end else begin
                rec_t r;
                r = sb.pop_front();
                chk("sb_line", 64'(out_line_index), 64'(r.line));
                chk("sb_mask", 64'(out_slot_mask), 64'(r.mask));
                chk("sb_count", 64'(out_count), 64'(r.cnt));
                chk("sb_cu", 64'(out_cu_id), 64'(r.cu));
                chk_data("sb_data", out_data, r.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        rec_t r;
        logic rdy;
        int   stalls;
        int   found;
        int   seen;

        tbl[0] = '{1'b1, 32'd40, 32'h40,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 32'd70, 32'h70,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 32'd70, 32'h70,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'd70, 32'h70,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 32'd0,  32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 32'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'd32, 32'h3200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 32'd33, 32'h3300, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 32'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 32'd0,  32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rstn = 1'b1; enabled_in = 1'b0; in_valid = 1'b0; in_index = '0; in_data = '0;
        in_cu_id = '0; flush_in = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_mask", 64'(out_slot_mask), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        chk_data("rst_data", out_data, 1024'd0);
        rstn = 1'b0;
        enabled_in = 1'b1;
        @(posedge clock);
        #1;

        // Full line of 32 consecutive elements; cu_id taken from the first element only.
        r = mk(27'd0, 8'h07);
        for (int k = 0; k < 32; k++) r = add(r, k, 32'(k));
        sb.push_back(r);
        stalls = 0;
        for (int k = 0; k < 32; k++) begin
            in_cu_id = (k == 0) ? 8'h07 : 8'h09;
            step(1'b1, 32'(k), 32'(k), 1'b0, 1'b1, rdy);
            if (!rdy) stalls++;
        end
        chk("full_stalls", 64'(stalls), 64'd0);
        chk("full_latency_valid", 64'(out_valid), 64'd1);
        chk("full_count", 64'(out_count), 64'd32);
        chk("full_slot5", 64'(out_data[5*32 +: 32]), 64'(exp_word(32'd5)));
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, rdy);
        chk("full_busy_after", 64'(busy_out), 64'd0);

        // Overwrite of one slot then timeout emission.
        in_cu_id = 8'h33;
        r = mk(27'd0, 8'h33);
        r = add(r, 3, 32'hAA);
        r = add(r, 3, 32'hBB);
        sb.push_back(r);
        step(1'b1, 32'd3, 32'hAA, 1'b0, 1'b1, rdy);
        step(1'b1, 32'd3, 32'hBB, 1'b0, 1'b1, rdy);
        found = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1'b0, 32'd3, 32'd0, 1'b0, 1'b1, rdy);
            if (out_valid) begin
                found = i;
                break;
            end
        end
        chk("timeout_idle_cycles", 64'(found), 64'd64);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, rdy);
        chk("timeout_busy_after", 64'(busy_out), 64'd0);

        // Table: line miss with held element, flush with accept, flush in IDLE.
        in_cu_id = 8'h22;
        r = mk(27'd1, 8'h22); r = add(r, 8, 32'h40); sb.push_back(r);
        r = mk(27'd2, 8'h22); r = add(r, 6, 32'h70); sb.push_back(r);
        r = mk(27'd1, 8'h22); r = add(r, 0, 32'h3200); r = add(r, 1, 32'h3300); sb.push_back(r);
        for (int t = 0; t < 10; t++) begin
            step(tbl[t].v, tbl[t].idx, tbl[t].dat, tbl[t].fl, tbl[t].ordy, rdy);
            chk($sformatf("tbl%0d_in_ready", t), 64'(rdy), 64'(tbl[t].e_rdy));
            chk($sformatf("tbl%0d_out_valid", t), 64'(out_valid), 64'(tbl[t].e_vld));
            chk($sformatf("tbl%0d_busy", t), 64'(busy_out), 64'(tbl[t].e_busy));
        end

        // Backpressure: record held stable for 10 cycles, handshake on the 11th.
        in_cu_id = 8'h44;
        r = mk(27'd2, 8'h44); r = add(r, 0, 32'h6400); sb.push_back(r);
        step(1'b1, 32'd64, 32'h6400, 1'b0, 1'b0, rdy);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, rdy);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 32'd96, 32'h9600, 1'b0, 1'b0, rdy);
            chk("bp_in_ready", 64'(rdy), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_line", 64'(out_line_index), 64'd2);
            chk("bp_mask", 64'(out_slot_mask), 64'd1);
            chk("bp_slot0", 64'(out_data[31:0]), 64'(exp_word(32'h6400)));
        end
        step(1'b1, 32'd96, 32'h9600, 1'b0, 1'b1, rdy);
        chk("bp_busy_after", 64'(busy_out), 64'd0);

        // Disabled: no accept, no timeout, no miss-emit; flush still drains the open line.
        in_cu_id = 8'h55;
        r = mk(27'd6, 8'h55); r = add(r, 8, 32'h2000); sb.push_back(r);
        step(1'b1, 32'd200, 32'h2000, 1'b0, 1'b1, rdy);
        enabled_in = 1'b0;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, rdy);
        stalls = 0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            step(1'b1, (c % 2 == 0) ? 32'd201 : 32'd300, 32'h1234, 1'b0, 1'b1, rdy);
            if (rdy) stalls++;
            if (out_valid) seen++;
        end
        chk("dis_in_ready_seen", 64'(stalls), 64'd0);
        chk("dis_out_valid_seen", 64'(seen), 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, rdy);
        chk("dis_flush_valid", 64'(out_valid), 64'd1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, rdy);
        chk("dis_busy_after", 64'(busy_out), 64'd0);
        enabled_in = 1'b1;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, rdy);

        // Asynchronous reset with a partially filled line; nothing must emerge afterwards.
        in_cu_id = 8'h66;
        for (int k = 0; k < 5; k++) step(1'b1, 32'(128 + k), 32'(k + 1), 1'b0, 1'b1, rdy);
        chk("pre_rst_count", 64'(out_count), 64'd5);
        #2 rstn = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy_out), 64'd0);
        chk("arst_mask", 64'(out_slot_mask), 64'd0);
        chk("arst_count", 64'(out_count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk_data("arst_data", out_data, 1024'd0);
        #2 rstn = 1'b0;
        @(posedge clock);
        #1;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, rdy);
            if (out_valid) seen++;
        end
        chk("post_rst_records", 64'(seen), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_edge_data_write_accumulate.md
Name: cu_edge_data_write_accumulate

Overview:
- Sits directly upstream of the CU edge data write control stage.
- Collects per-edge 32-bit data writes from the CU compute pipeline and coalesces writes that land in the same 128-byte cacheline into a single line-wide record.
- Each record carries a slot mask, so downstream issues one cacheline write command instead of one per element.
- Cuts CAPI write command traffic for dense index streams.

Parameters:
- DATA_WIDTH, 32, element width in bits (DATA_SIZE_WRITE_BITS).
- CACHELINE_BYTES, 128, cacheline size in bytes.
- SLOTS, CACHELINE_BYTES*8/DATA_WIDTH = 32, elements per line.
- INDEX_WIDTH, 32, element index width.
- TIMEOUT_CYCLES, 64, idle cycles before a partial line is emitted.

Ports:
- clock  in  1  clock.
- rstn  in  1  reset; asynchronous, active-high (asserted = 1).
- enabled_in  in  1  block enable; registered internally, one cycle of delay.
- in_valid  in  1  element write valid.
- in_index  in  INDEX_WIDTH  element index.
- in_data  in  DATA_WIDTH  element data.
- in_cu_id  in  8  originating CU id.
- in_ready  out  1  element accepted when in_valid && in_ready.
- flush_in  in  1  force emission of the open line.
- out_valid  out  1  line record valid.
- out_ready  in  1  downstream accepts the record.
- out_line_index  out  INDEX_WIDTH-log2(SLOTS)  in_index >> log2(SLOTS) of the line.
- out_data  out  CACHELINE_BYTES*8  line data; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_slot_mask  out  SLOTS  bit k set means slot k was written.
- out_cu_id  out  8  cu_id of the first element in the line.
- out_count  out  log2(SLOTS)+1  number of distinct slots written.
- busy_out  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, in_ready 0, state IDLE, mask/data/count/timer cleared, enabled reg 0. Reset mid-line discards the line with no emission.
- Accept condition: in_ready = enabled && state != EMIT && !(state == ACCUM && line(in_index) != open line). Combinational from state and in_index.
- slot = in_index[log2(SLOTS)-1:0]; line = in_index >> log2(SLOTS).
- IDLE, on accept:
  - capture line and cu_id; write slot; mask = 1<<slot; count = 1; timer = 0.
  - go to ACCUM.
- ACCUM, on accept of the same line:
  - write slot data.
  - If mask bit is already set: data overwritten (last write wins); mask and count unchanged.
  - Otherwise: set the mask bit and increment count.
  - Timer resets to 0.
- ACCUM, go to EMIT on the first of:
  - the mask becomes all-ones, including on the accepting cycle;
  - in_valid with a different line (not accepted; held by the source);
  - flush_in = 1;
  - timer == TIMEOUT_CYCLES-1 with no accept that cycle.
- Timer counts only while enabled and in ACCUM with no accept. It saturates; it never wraps.
- Flush and an accepting element in the same cycle: the element is included, then EMIT.
- flush_in in IDLE: ignored.
- EMIT:
  - out_valid = 1; out_* registered and held stable until out_ready.
  - On handshake: mask, count and timer cleared; state IDLE.
  - in_ready = 0 throughout EMIT, so the mismatched element is accepted the cycle after the handshake.
- Latency: the element that completes the line at clock edge N gives out_valid = 1 after edge N (visible from cycle N+1).
- Throughput: one element per cycle. One idle input cycle per emitted line (the EMIT cycle with out_ready held high).
- enabled low:
  - in_ready = 0 and the timer is frozen.
  - A pending EMIT still drains.
  - The open line is kept until enabled returns or flush_in is asserted.
- out_data slots whose mask bit is 0 are driven 0.

Optional Feature:
- Macro: CU_WRITE_ACCUM_ENDIAN_SWAP_EN.
- Defined: in_data is byte-reversed per element on insertion, so out_data is big-endian per slot for CAPI. Downstream must then skip its own swap.
- Undefined: data stored unmodified. The swap is left to the downstream write stage.
- Mask, count and timing are identical in both builds.

Test Plan:
- Indices 0..31 consecutive, data = index, out_ready = 1 → one record after element 31: out_line_index 0, out_slot_mask 0xFFFFFFFF, out_count 32, slot 5 = 0x00000005. No idle cycles before the EMIT cycle.
- Indices 3, 3 with data 0xAA then 0xBB, then idle 64 cycles → timeout record: mask 0x00000008, count 1, slot 3 = 0xBB.
- Index 40 then index 70 → record line 1, mask 0x00000100, emitted. Index 70 held with in_ready 0, accepted after the handshake, then forms line 2 with mask 0x00000040.
- flush_in asserted together with index 33 after index 32 was accepted → record line 1, mask 0x00000003, count 2.
- Line emitted with out_ready = 0 for 10 cycles → out_* stable, in_ready = 0. Handshake on cycle 11 → IDLE, busy_out = 0.
- Reset asserted in ACCUM with 5 slots written → all outputs 0 immediately (asynchronous). No record appears after reset release.
